// File: rtl/quad_pkg.sv
// Shared constants and transition classification for the quadrature decoder.
package quad_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  localparam int unsigned DEFAULT_FILTER = 3;

  typedef enum logic [1:0] {
    StepNone,
    StepUp,
    StepDown,
    StepBad
  } step_e;

  // Classify a {A,B} state change; a two-bit change has no defined direction.
  function automatic step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
    step_e res;
    if (prev == cur) begin
      res = StepNone;
    end else if ((prev ^ cur) == 2'b11) begin
      res = StepBad;
    end else begin
      unique case ({prev, cur})
        {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: res = StepUp;
        default:                                         res = StepDown;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one encoder phase.
module quad_filter
  import quad_pkg::*;
#(
  parameter int unsigned FILTER = DEFAULT_FILTER
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam logic [3:0] RunLimit = 4'(FILTER);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [3:0] run_q, run_d;
  logic [3:0] run_inc;

  assign run_inc = run_q + 4'd1;

  always_comb begin
    filt_d = filt_q;
    run_d  = 4'd0;
    if (sync2_q != filt_q) begin
      if (run_inc == RunLimit) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      run_q   <= 4'd0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      run_q   <= run_d;
    end
  end

  assign out = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases to registered step/dir pulses and a wrapping count.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned FILTER = DEFAULT_FILTER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             error
);

  logic             filt_a, filt_b;
  logic [1:0]       cur, prev_q;
  step_e            delta;
  logic             step_q, step_d;
  logic             error_q, error_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] count_q, count_d;

  quad_filter #(.FILTER(FILTER)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .in    (a_in),
    .out   (filt_a)
  );

  quad_filter #(.FILTER(FILTER)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .in    (b_in),
    .out   (filt_b)
  );

  assign cur   = {filt_a, filt_b};
  assign delta = quad_step(prev_q, cur);

  always_comb begin
    step_d  = 1'b0;
    error_d = 1'b0;
    dir_d   = dir_q;
    count_d = count_q;
    unique case (delta)
      StepUp: begin
        step_d  = 1'b1;
        dir_d   = 1'b1;
        count_d = count_q + 1'b1;
      end
      StepDown: begin
        step_d  = 1'b1;
        dir_d   = 1'b0;
        count_d = count_q - 1'b1;
      end
      StepBad:  error_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= Q00;
      step_q  <= 1'b0;
      error_q <= 1'b0;
      dir_q   <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= cur;
      step_q  <= step_d;
      error_q <= error_d;
      dir_q   <= dir_d;
      count_q <= count_d;
    end
  end

  assign step  = step_q;
  assign error = error_q;
  assign dir   = dir_q;
  assign count = count_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench: expected step/error events are queued when phases are driven.
module tb_quad_decoder;

  localparam int FILT = 3;
  localparam int LAT  = 2 + FILT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       step, dir, error;
  logic [3:0] count;

  typedef struct {
    int         due;
    bit         err;
    bit         dir;
    logic [3:0] cnt;
  } ev_t;

  ev_t        sbq[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [1:0] m_prev = 2'b00;
  logic [3:0] m_count = 4'd0;
  logic       m_dir = 1'b0;

  quad_decoder #(.WIDTH(4), .FILTER(FILT)) dut (
    .clk   (clk),
    .reset (reset),
    .a_in  (a_in),
    .b_in  (b_in),
    .step  (step),
    .dir   (dir),
    .count (count),
    .error (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Position along the up sequence 00,01,11,10.
  function automatic int gpos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (step && error) check("exclusive", 1, 0);
    if (step || error) begin
      if (sbq.size() == 0) begin
        check("unexpected_event", {30'd0, step, error}, 0);
      end else begin
        e = sbq.pop_front();
        check("event_cycle", cyc, e.due);
        check("event_kind", error, e.err);
        if (!e.err) check("event_dir", dir, e.dir);
        check("event_count", count, e.cnt);
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
      check("missed_event", cyc, sbq[0].due);
      void'(sbq.pop_front());
    end
  end

  // Drive a phase state at a negedge and hold it; only long holds qualify.
  task automatic apply(input logic a, input logic b, input int hold);
    logic [1:0] cur;
    int         d;
    ev_t        e;
    cur  = {a, b};
    a_in = a;
    b_in = b;
    if (hold >= FILT && cur != m_prev) begin
      d = (gpos(cur) - gpos(m_prev) + 4) % 4;
      e.due = cyc + 1 + LAT;
      e.err = (d == 2);
      if (d == 1) begin
        m_count = m_count + 4'd1;
        m_dir   = 1'b1;
      end else if (d == 3) begin
        m_count = m_count - 4'd1;
        m_dir   = 1'b0;
      end
      e.dir = m_dir;
      e.cnt = m_count;
      sbq.push_back(e);
      m_prev = cur;
    end
    repeat (hold) @(negedge clk);
    if (hold > LAT) begin
      check("count", count, m_count);
      check("dir", dir, m_dir);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("rst_step", step, 0);
      check("rst_error", error, 0);
      check("rst_count", count, 0);
    end
    check("rst_dir", dir, 0);
    check("rst_queue", sbq.size(), 0);
    reset   = 1'b0;
    m_prev  = 2'b00;
    m_count = 4'd0;
    m_dir   = 1'b0;
  endtask

  initial begin
    // Reset with the encoder idling at 11: one error after release.
    a_in = 1'b1;
    b_in = 1'b1;
    @(negedge clk);
    do_reset(3);
    apply(1'b1, 1'b1, 10);
    apply(1'b1, 1'b0, 8);
    apply(1'b0, 1'b0, 8);

    // Four up steps from a clean zero.
    do_reset(2);
    apply(1'b0, 1'b1, 8);
    apply(1'b1, 1'b1, 8);
    apply(1'b1, 1'b0, 8);
    apply(1'b0, 1'b0, 8);
    check("up_count", count, 4);

    // Down wrap through zero.
    do_reset(2);
    apply(1'b1, 1'b0, 8);
    check("wrap_down", count, 15);
    apply(1'b1, 1'b1, 8);
    check("down_14", count, 14);

    // Up to 15, then overflow to 0.
    apply(1'b1, 1'b0, 8);
    apply(1'b0, 1'b0, 8);
    check("wrap_up", count, 0);

    // Glitches: 2 cycles rejected, 3 cycles accepted both ways.
    apply(1'b1, 1'b0, 2);
    apply(1'b0, 1'b0, 10);
    check("glitch2_count", count, 0);
    apply(1'b1, 1'b0, 3);
    apply(1'b0, 1'b0, 10);
    check("glitch3_count", count, 0);

    // Simultaneous change is illegal.
    apply(1'b0, 1'b1, 8);
    apply(1'b0, 1'b0, 8);
    apply(1'b1, 1'b1, 8);
    apply(1'b1, 1'b0, 8);
    apply(1'b0, 1'b0, 8);

    // Reset one cycle after an A edge discards it.
    a_in = 1'b1;
    @(negedge clk);
    a_in = 1'b0;
    do_reset(2);
    repeat (12) @(negedge clk);
    check("midfilt_count", count, 0);
    check("final_queue", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
